uart_byte_rx: RTL and testbench
===============================

UART_BYTE_RX -- requirements
Module: uart_byte_rx

Interface
REQ-001 The block SHALL have parameter bps_DR, default 5207, meaning the bit-period divider maximum; one bit lasts bps_DR+1 clk cycles (9600 baud at 50 MHz).
REQ-002 The block SHALL have port clk, input, 1 bit: the single module clock, 50 MHz, with all logic on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port uart_rx, input, 1 bit: asynchronous serial line, idle high.
REQ-005 The block SHALL have port data_byte, output, 8 bits: the last correctly framed byte received, LSB first on the line.
REQ-006 The block SHALL have port rx_done, output, 1 bit: a one-cycle pulse when data_byte has been updated.
REQ-007 The block SHALL have port frame_err, output, 1 bit: a one-cycle pulse when the stop bit is sampled low.
REQ-008 The block SHALL have port uart_state, output, 1 bit: high while a frame is being received (any state other than IDLE).

Function
REQ-009 uart_rx SHALL pass through a 2-flop synchronizer, with both flops reset to 1, before any other use.
REQ-010 In IDLE, a falling edge on the synchronized line (previous 1, current 0) SHALL move the block to START, with div_cnt=0.
REQ-011 Outside IDLE, div_cnt SHALL count 0..bps_DR and wrap to 0; in IDLE it SHALL be held at 0.
REQ-012 The sample point SHALL be div_cnt == bps_DR/2 (integer divide); all line decisions SHALL be made only at the sample point.
REQ-013 START state, at the sample point:
- line 0 -> go to DATA with bit index 0;
- line 1 -> go back to IDLE as a glitch, with no pulse on any output.
REQ-014 DATA state: at each sample point, shift the line into bit index 0..7 of an internal shift register, LSB first; after index 7, go to STOP.
REQ-015 STOP state, at the sample point:
- line 1 -> load data_byte from the shift register and pulse rx_done for 1 cycle;
- line 0 -> pulse frame_err for 1 cycle and leave data_byte unchanged;
- in both cases, go to IDLE.
REQ-016 rx_done and frame_err SHALL assert in the cycle after the stop-bit sample and SHALL never be high together.
REQ-017 Returning to IDLE at the middle of the stop bit SHALL allow a start edge that immediately follows the stop bit to be accepted, so back-to-back frames are received without loss.
REQ-018 Line activity outside the sample points SHALL have no effect, except for start-edge detection in IDLE.
REQ-019 Width rules: div_cnt SHALL be 16 bits and the bit index SHALL be 3 bits; bps_DR values up to 65535 SHALL be supported.
REQ-020 uart_state SHALL be registered, and high from the cycle after start-edge detection until the cycle after the stop-bit sample.

Reset
REQ-021 rst=1 at any clk edge, including mid-frame, SHALL set the outputs to: data_byte=8'h00, rx_done=0, frame_err=0, uart_state=0.
REQ-022 rst=1 SHALL also set internal state to: state=IDLE, div_cnt=0, bit index=0, shift register=0, synchronizer flops=1.
REQ-023 A frame interrupted by reset SHALL produce no rx_done or frame_err; the next complete frame SHALL be received normally.

Structure
REQ-024 State encodings (IDLE, START, DATA, STOP) and START_BIT=0 / STOP_BIT=1 SHALL live in a shared UART package or include file, shared with the transmitter.
REQ-025 One sub-module is natural: uart_rx_sync, containing the 2-flop synchronizer plus falling-edge detect, with outputs rx_s and rx_fall.

Verification (bps_DR=9, 10 clk per bit, in all scenarios)
REQ-026 Frame 0x55 with a valid stop bit -> exactly one rx_done pulse, data_byte=0x55, frame_err=0.
REQ-027 Frames 0xA3 then 0x0F back-to-back with no idle gap -> two rx_done pulses, 10 bit-times apart, with data_byte values 0xA3 then 0x0F.
REQ-028 uart_rx low for 3 clk, then high -> no rx_done, no frame_err; uart_state returns to 0 within 7 clk.
REQ-029 Frame 0x3C with stop bit 0 -> one frame_err pulse, no rx_done; data_byte keeps its previous value.
REQ-030 rst pulsed during data bit 4 of a frame, then frame 0x81 sent -> all outputs are 0 the cycle after rst; no pulse for the aborted frame; data_byte=0x81 with one rx_done.

Source files
------------

// File: rtl/uart_byte_rx_pkg.sv
// rtl/uart_byte_rx_pkg.sv - UART frame states and line levels shared by receiver and transmitter
package uart_byte_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_fsm_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the serial line plus falling-edge detect
module uart_rx_sync
  import uart_byte_rx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic uart_rx,
  output logic rx_s,
  output logic rx_fall
);

  logic rx_meta;
  logic rx_prev;

  // All flops reset to the idle line level so reset release never fakes a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= STOP_BIT;
      rx_s    <= STOP_BIT;
      rx_prev <= STOP_BIT;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign rx_fall = (rx_prev == STOP_BIT) && (rx_s == START_BIT);

endmodule

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - 8N1 UART byte receiver sampling each bit at its midpoint
module uart_byte_rx
  import uart_byte_rx_pkg::*;
#(
  parameter int unsigned bps_DR = 5207
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] data_byte,
  output logic       rx_done,
  output logic       frame_err,
  output logic       uart_state
);

  localparam logic [15:0] DIV_MAX    = 16'(bps_DR);
  localparam logic [15:0] DIV_SAMPLE = 16'(bps_DR / 2);

  logic        rx_s;
  logic        rx_fall;
  uart_fsm_e   state;
  logic [15:0] div_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_reg;
  logic        sample;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .uart_rx (uart_rx),
    .rx_s    (rx_s),
    .rx_fall (rx_fall)
  );

  assign sample = (div_cnt == DIV_SAMPLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      div_cnt    <= 16'd0;
      bit_idx    <= 3'd0;
      shift_reg  <= 8'h00;
      data_byte  <= 8'h00;
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
      uart_state <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;

      if (state == IDLE || div_cnt == DIV_MAX) begin
        div_cnt <= 16'd0;
      end else begin
        div_cnt <= div_cnt + 16'd1;
      end

      case (state)
        IDLE: begin
          if (rx_fall) begin
            state      <= START;
            uart_state <= 1'b1;
          end
        end
        START: begin
          if (sample) begin
            if (rx_s == START_BIT) begin
              state   <= DATA;
              bit_idx <= 3'd0;
            end else begin
              state      <= IDLE;
              div_cnt    <= 16'd0;
              uart_state <= 1'b0;
            end
          end
        end
        DATA: begin
          if (sample) begin
            shift_reg[bit_idx] <= rx_s;
            bit_idx            <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          // Leaving at mid stop bit lets an immediately following start edge be caught.
          if (sample) begin
            if (rx_s == STOP_BIT) begin
              data_byte <= shift_reg;
              rx_done   <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state      <= IDLE;
            div_cnt    <= 16'd0;
            uart_state <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          div_cnt    <= 16'd0;
          uart_state <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb/tb_uart_byte_rx.sv - directed and randomized frame checks for uart_byte_rx
module tb_uart_byte_rx;

  localparam int BPS     = 9;
  localparam int BIT_CLK = BPS + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rx;
  logic [7:0] data_byte;
  logic       rx_done;
  logic       frame_err;
  logic       uart_state;

  int         checks   = 0;
  int         failures = 0;
  int         done_cnt = 0;
  int         err_cnt  = 0;
  int         both_cnt = 0;
  longint     cyc      = 0;
  longint     done_t[$];
  logic [7:0] done_val[$];

  always #5 clk = ~clk;

  uart_byte_rx #(.bps_DR(BPS)) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_rx    (uart_rx),
    .data_byte  (data_byte),
    .rx_done    (rx_done),
    .frame_err  (frame_err),
    .uart_state (uart_state)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_done) begin
      done_cnt++;
      done_t.push_back(cyc);
      done_val.push_back(data_byte);
    end
    if (frame_err) err_cnt++;
    if (rx_done && frame_err) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    uart_rx = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  initial begin
    int         d0;
    int         e0;
    int         exp_done;
    int         exp_err;
    logic [7:0] exp_data;
    logic [7:0] rb;
    logic       rs;
    logic [7:0] ab;
    bit         ok;

    rst     = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data_byte", 32'(data_byte), 32'h00);
    check("reset_rx_done", 32'(rx_done), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_uart_state", 32'(uart_state), 32'h0);
    rst = 1'b0;
    idle(5);

    // single good frame
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h55, 1'b1);
    idle(3);
    check("f55_done_count", 32'(done_cnt - d0), 32'd1);
    check("f55_data", 32'(data_byte), 32'h55);
    check("f55_err_count", 32'(err_cnt - e0), 32'd0);

    // back-to-back frames
    d0 = done_cnt;
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    idle(3);
    check("b2b_done_count", 32'(done_cnt - d0), 32'd2);
    if (done_val.size() >= 2) begin
      check("b2b_first", 32'(done_val[done_val.size()-2]), 32'hA3);
      check("b2b_second", 32'(done_val[done_val.size()-1]), 32'h0F);
      check("b2b_spacing", 32'(done_t[done_t.size()-1] - done_t[done_t.size()-2]), 32'(10 * BIT_CLK));
    end
    check("b2b_data", 32'(data_byte), 32'h0F);

    // 3-clk glitch
    idle(10);
    d0 = done_cnt; e0 = err_cnt;
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    check("glitch_state_high", 32'(uart_state), 32'h1);
    uart_rx = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (uart_state == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check("glitch_state_return", 32'(ok), 32'h1);
    idle(30);
    check("glitch_no_done", 32'(done_cnt - d0), 32'd0);
    check("glitch_no_err", 32'(err_cnt - e0), 32'd0);

    // bad stop bit
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h3C, 1'b0);
    idle(12);
    check("ferr_err_count", 32'(err_cnt - e0), 32'd1);
    check("ferr_no_done", 32'(done_cnt - d0), 32'd0);
    check("ferr_data_kept", 32'(data_byte), 32'h0F);

    // reset during data bit 4
    d0 = done_cnt; e0 = err_cnt;
    ab = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(ab[i]);
    uart_rx = ab[4];
    repeat (BIT_CLK / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_data_byte", 32'(data_byte), 32'h00);
    check("midrst_rx_done", 32'(rx_done), 32'h0);
    check("midrst_frame_err", 32'(frame_err), 32'h0);
    check("midrst_uart_state", 32'(uart_state), 32'h0);
    idle(4 * BIT_CLK);
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    check("midrst_no_err", 32'(err_cnt - e0), 32'd0);
    send_frame(8'h81, 1'b1);
    idle(3);
    check("after_rst_done", 32'(done_cnt - d0), 32'd1);
    check("after_rst_data", 32'(data_byte), 32'h81);

    // randomized frames against a byte-level model
    exp_done = done_cnt;
    exp_err  = err_cnt;
    exp_data = 8'h81;
    for (int n = 0; n < 10; n++) begin
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rb, rs);
      if (rs) begin
        exp_done++;
        exp_data = rb;
      end else begin
        exp_err++;
      end
      idle(BIT_CLK);
      check("rand_done_count", 32'(done_cnt), 32'(exp_done));
      check("rand_err_count", 32'(err_cnt), 32'(exp_err));
      check("rand_data", 32'(data_byte), 32'(exp_data));
      check("rand_state_idle", 32'(uart_state), 32'h0);
      idle($urandom_range(0, 20));
    end

    check("never_both_pulses", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
